dff_bank_write_scheduler: RTL and testbench

//  Shares one register bank of DEPTH x WIDTH edge-triggered D flip-flops among NREQ write requesters.

---
 rtl/dff_bank_write_scheduler_pkg.sv | 14 +
 rtl/dff_bank_write_scheduler_if.sv | 24 ++
 rtl/dff_bank_write_scheduler_word.sv | 33 +++
 rtl/dff_bank_write_scheduler.sv | 78 +++++++
 tb/tb_dff_bank_write_scheduler.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/dff_bank_write_scheduler_pkg.sv
// Shared constants and helpers for the DFF bank write scheduler.
// Covers bank geometry, requester count and grant encoding.
package dff_bank_write_scheduler_pkg;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int OW    = $clog2(NREQ);

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/dff_bank_write_scheduler_if.sv
// Requester/reader bus of the DFF bank write scheduler.
// The master drives requests and read addresses; the slave is the scheduler.
interface dff_bank_write_scheduler_if;
  import dff_bank_write_scheduler_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic                  hold;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         wr_owner;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;

  modport master (
    output req, wr_addr, wr_data, hold, rd_addr,
    input  gnt, wr_owner, rd_data
  );

  modport slave (
    input  req, wr_addr, wr_data, hold, rd_addr,
    output gnt, wr_owner, rd_data
  );
endinterface

// File: rtl/dff_bank_write_scheduler_word.sv
// One bank word built from discrete edge-triggered flip-flops.
// Clear and load-enable are folded into each bit's D input.
module d_flip_flop_edge_triggered (
  input  logic C,
  input  logic D,
  output logic Q
);
  always_ff @(posedge C) begin
    Q <= D;
  end
endmodule

module dff_word_le
  import dff_bank_write_scheduler_pkg::*;
(
  input  logic             C,
  input  logic             R,
  input  logic             LE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic d_bit;
      assign d_bit = R ? 1'b0 : (LE ? D[gi] : Q[gi]);
      d_flip_flop_edge_triggered u_ff (
        .C (C),
        .D (d_bit),
        .Q (Q[gi])
      );
    end
  endgenerate
endmodule

// File: rtl/dff_bank_write_scheduler.sv
// Round-robin write scheduler owning a DEPTH x WIDTH flip-flop bank.
// One requester commits per edge; the read port is a plain mux of flop outputs.
module dff_bank_write_scheduler
  import dff_bank_write_scheduler_pkg::*;
(
  input  logic                      C,
  input  logic                      R,
  dff_bank_write_scheduler_if.slave bus
);
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q;
  logic [OW-1:0]    owner_q;
  logic [OW-1:0]    win;
  logic             found;
  logic             arb;
  logic [AW-1:0]    wr_addr_w;
  logic [WIDTH-1:0] wr_data_w;
  logic [DEPTH-1:0] le;
  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] rd_data;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    logic [OW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = OW'((int'(ptr_q) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign arb       = !R && !bus.hold && found;
  assign wr_addr_w = bus.wr_addr[win*AW +: AW];
  assign wr_data_w = bus.wr_data[win*WIDTH +: WIDTH];
  assign ptr_d     = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;

  // Out-of-range addresses match no word, so the write is silently dropped.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      assign le[gi] = arb && (wr_addr_w == AW'(gi));
      dff_word_le u_word (
        .C  (C),
        .R  (R),
        .LE (le[gi]),
        .D  (wr_data_w),
        .Q  (bank_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge C) begin
    if (R) begin
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else if (arb) begin
      gnt_q   <= onehot(win);
      owner_q <= win;
      ptr_q   <= ptr_d;
    end else begin
      gnt_q   <= '0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(bus.rd_addr) < DEPTH) rd_data = bank_q[bus.rd_addr];
  end

  assign bus.gnt      = gnt_q;
  assign bus.wr_owner = owner_q;
  assign bus.rd_data  = rd_data;
endmodule

// File: tb/tb_dff_bank_write_scheduler.sv
// Directed bench for dff_bank_write_scheduler with a grant scoreboard.
// Expected grants are queued when a request is driven and checked after the edge.
module tb_dff_bank_write_scheduler;
  import dff_bank_write_scheduler_pkg::*;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [OW-1:0]   owner;
  } exp_t;

  logic C = 1'b0;
  logic R;
  int   passed = 0;
  int   total  = 0;
  exp_t sb_q[$];
  logic [WIDTH-1:0] exp_bank [DEPTH];

  dff_bank_write_scheduler_if bus ();

  dff_bank_write_scheduler dut (
    .C   (C),
    .R   (R),
    .bus (bus.slave)
  );

  always #5 C = ~C;

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus.wr_addr[i*AW +: AW]       = a;
    bus.wr_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Drive req, queue the expected grant, clock once, then score it.
  task automatic cycle(input string tag, input logic [NREQ-1:0] r,
                       input logic [NREQ-1:0] eg, input logic [OW-1:0] eo);
    exp_t e;
    bus.req = r;
    e.gnt   = eg;
    e.owner = eo;
    sb_q.push_back(e);
    tick();
    e = sb_q.pop_front();
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(e.gnt));
    chk({tag, "_owner"}, 32'(bus.wr_owner), 32'(e.owner));
    $display("txn %s req=%b gnt=%b owner=%0d", tag, r, bus.gnt, bus.wr_owner);
  endtask

  task automatic check_bank(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = AW'(a);
      #1;
      chk($sformatf("%s_word%0d", tag, a), 32'(bus.rd_data), 32'(exp_bank[a]));
    end
  endtask

  initial begin
    R           = 1'b1;
    bus.req     = 4'b1111;
    bus.hold    = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int i = 0; i < NREQ; i++) set_wr(i, AW'(i), 8'hF0 + 8'(i));
    for (int a = 0; a < DEPTH; a++) exp_bank[a] = '0;

    // 1: reset dominates pending requests
    cycle("reset1", 4'b1111, 4'b0000, 2'd0);
    cycle("reset2", 4'b1111, 4'b0000, 2'd0);
    check_bank("reset");
    R = 1'b0;
    cycle("idle", 4'b0000, 4'b0000, 2'd0);

    // 2: single write, then confirm ptr=3 by contention between 0 and 3
    set_wr(2, 2'd3, 8'hA5);
    cycle("single", 4'b0100, 4'b0100, 2'd2);
    exp_bank[3] = 8'hA5;
    bus.rd_addr = 2'd3;
    #1;
    chk("single_rd", 32'(bus.rd_data), 32'h00A5);
    set_wr(3, 2'd0, 8'h5A);
    cycle("ptr3", 4'b1001, 4'b1000, 2'd3);
    exp_bank[0] = 8'h5A;

    // 3: round-robin with all requesters held from ptr=0
    for (int i = 0; i < NREQ; i++) set_wr(i, AW'(i), 8'h10 + 8'(i));
    for (int k = 0; k < 8; k++) begin
      logic [NREQ-1:0] g;
      g = '0;
      g[k % NREQ] = 1'b1;
      cycle($sformatf("rr%0d", k), 4'b1111, g, OW'(k % NREQ));
    end
    for (int a = 0; a < DEPTH; a++) exp_bank[a] = 8'h10 + 8'(a);
    check_bank("rr");

    // 4: collision on addr 1 from ptr=1
    set_wr(0, 2'd0, 8'h77);
    cycle("toptr1", 4'b0001, 4'b0001, 2'd0);
    exp_bank[0] = 8'h77;
    set_wr(0, 2'd1, 8'h11);
    set_wr(1, 2'd1, 8'h22);
    cycle("coll_a", 4'b0011, 4'b0010, 2'd1);
    bus.rd_addr = 2'd1;
    #1;
    chk("coll_mid", 32'(bus.rd_data), 32'h0022);
    cycle("coll_b", 4'b0001, 4'b0001, 2'd0);
    exp_bank[1] = 8'h11;
    check_bank("coll");

    // 5: hold freezes everything, reset clears the bank and ptr
    bus.hold = 1'b1;
    set_wr(0, 2'd2, 8'hEE);
    set_wr(1, 2'd3, 8'hDD);
    cycle("hold1", 4'b0011, 4'b0000, 2'd0);
    cycle("hold2", 4'b0011, 4'b0000, 2'd0);
    check_bank("hold");
    bus.hold = 1'b0;
    R = 1'b1;
    cycle("midrst", 4'b0011, 4'b0000, 2'd0);
    R = 1'b0;
    for (int a = 0; a < DEPTH; a++) exp_bank[a] = '0;
    check_bank("midrst");
    set_wr(0, 2'd0, 8'h01);
    cycle("postrst", 4'b0011, 4'b0001, 2'd0);
    exp_bank[0] = 8'h01;

    // 6: read-during-write on addr 2
    set_wr(2, 2'd2, 8'h3C);
    bus.rd_addr = 2'd2;
    bus.req     = 4'b0100;
    #1;
    chk("rdw_before", 32'(bus.rd_data), 32'h0000);
    cycle("rdw", 4'b0100, 4'b0100, 2'd2);
    chk("rdw_after", 32'(bus.rd_data), 32'h003C);
    bus.req = 4'b0000;
    cycle("final_idle", 4'b0000, 4'b0000, 2'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
